// File: rtl/ex_stage_md.sv
// Execute stage: forwarding muxes, single-cycle ALU, iterative unsigned mul/div
// and the EX/MEM output register.
module ex_stage_md #(
  parameter int WIDTH   = 32,
  parameter int RADDR_W = 5,
  parameter int OP_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [OP_W-1:0]    alu_op,
  input  logic               alu_src,
  input  logic               reg_dst,
  input  logic [WIDTH-1:0]   imm,
  input  logic [2:0]         fwd_a,
  input  logic [2:0]         fwd_b,
  input  logic [WIDTH-1:0]   id_ex_a,
  input  logic [WIDTH-1:0]   id_ex_b,
  input  logic [WIDTH-1:0]   ex_mem_fwd,
  input  logic [WIDTH-1:0]   mem_wb_fwd,
  input  logic [RADDR_W-1:0] rs,
  input  logic [RADDR_W-1:0] rt,
  input  logic [RADDR_W-1:0] rd,
  input  logic               mem_hold,
  input  logic               flush,
  output logic               ex_busy,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_result,
  output logic [WIDTH-1:0]   out_store,
  output logic [RADDR_W-1:0] out_dest
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = SH_W + 1;

  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_NOR   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(9);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_MUL   = OP_W'(16);
  localparam logic [OP_W-1:0] OP_MULHU = OP_W'(17);
  localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(18);
  localparam logic [OP_W-1:0] OP_REMU  = OP_W'(19);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [WIDTH-1:0]   hi_reg, hi_next;
  logic [WIDTH-1:0]   lo_reg, lo_next;
  logic [WIDTH-1:0]   md_b_reg, md_b_next;
  logic [WIDTH-1:0]   md_store_reg, md_store_next;
  logic [RADDR_W-1:0] md_dest_reg, md_dest_next;
  logic [1:0]         md_sel_reg, md_sel_next;
  logic               out_valid_reg, out_valid_next;
  logic [WIDTH-1:0]   out_result_reg, out_result_next;
  logic [WIDTH-1:0]   out_store_reg, out_store_next;
  logic [RADDR_W-1:0] out_dest_reg, out_dest_next;

  logic [WIDTH-1:0]   op_a, fwd_b_val, op_b, alu_result;
  logic [RADDR_W-1:0] dest;
  logic               is_md;
  logic               unused_rs;

  assign unused_rs = ^rs;

  // Only clean one-hot codes pick a bypass path; everything else falls back to ID/EX.
  always_comb begin
    case (fwd_a)
      3'b010:  op_a = ex_mem_fwd;
      3'b100:  op_a = mem_wb_fwd;
      default: op_a = id_ex_a;
    endcase
    case (fwd_b)
      3'b010:  fwd_b_val = ex_mem_fwd;
      3'b100:  fwd_b_val = mem_wb_fwd;
      default: fwd_b_val = id_ex_b;
    endcase
  end

  assign op_b  = alu_src ? imm : fwd_b_val;
  assign dest  = reg_dst ? rd : rt;
  assign is_md = (alu_op == OP_MUL) || (alu_op == OP_MULHU) ||
                 (alu_op == OP_DIVU) || (alu_op == OP_REMU);

  always_comb begin
    alu_result = '0;
    case (alu_op)
      OP_ADD:  alu_result = op_a + op_b;
      OP_SUB:  alu_result = op_a - op_b;
      OP_AND:  alu_result = op_a & op_b;
      OP_OR:   alu_result = op_a | op_b;
      OP_XOR:  alu_result = op_a ^ op_b;
      OP_NOR:  alu_result = ~(op_a | op_b);
      OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      OP_SLL:  alu_result = op_a << op_b[SH_W-1:0];
      OP_SRL:  alu_result = op_a >> op_b[SH_W-1:0];
      OP_SRA:  alu_result = $unsigned($signed(op_a) >>> op_b[SH_W-1:0]);
      default: alu_result = '0;
    endcase
  end

  // One iteration step. Multiply: {hi,lo} holds {partial product, remaining multiplier}.
  // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, md_b_reg} : '0);
    div_shift = {hi_reg, lo_reg[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, md_b_reg});
    div_diff  = div_shift[WIDTH-1:0] - md_b_reg;
    if (md_sel_reg[1]) begin
      step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      step_lo = {lo_reg[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    hi_next         = hi_reg;
    lo_next         = lo_reg;
    md_b_next       = md_b_reg;
    md_store_next   = md_store_reg;
    md_dest_next    = md_dest_reg;
    md_sel_next     = md_sel_reg;
    out_valid_next  = out_valid_reg;
    out_result_next = out_result_reg;
    out_store_next  = out_store_reg;
    out_dest_next   = out_dest_reg;
    ex_busy         = 1'b0;
    case (state_reg)
      IDLE: begin
        ex_busy = in_valid & is_md;
        if (flush) begin
          out_valid_next = 1'b0;
          count_next     = '0;
        end else if (!mem_hold) begin
          if (in_valid && is_md) begin
            hi_next        = '0;
            lo_next        = op_a;
            md_b_next      = op_b;
            md_store_next  = fwd_b_val;
            md_dest_next   = dest;
            md_sel_next    = alu_op[1:0];
            count_next     = CNT_W'(WIDTH);
            out_valid_next = 1'b0;
            state_next     = RUN;
          end else if (in_valid) begin
            out_valid_next  = 1'b1;
            out_result_next = alu_result;
            out_store_next  = fwd_b_val;
            out_dest_next   = dest;
          end else begin
            out_valid_next = 1'b0;
          end
        end
      end
      RUN: begin
        ex_busy = (count_reg != CNT_W'(1)) | mem_hold;
        if (flush) begin
          out_valid_next = 1'b0;
          count_next     = '0;
          state_next     = IDLE;
        end else if (count_reg == CNT_W'(1)) begin
          // Last step retires straight into EX/MEM; a downstream hold parks it here.
          if (!mem_hold) begin
            out_valid_next  = 1'b1;
            out_result_next = md_sel_reg[0] ? step_hi : step_lo;
            out_store_next  = md_store_reg;
            out_dest_next   = md_dest_reg;
            count_next      = '0;
            state_next      = IDLE;
          end
        end else begin
          hi_next    = step_hi;
          lo_next    = step_lo;
          count_next = count_reg - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      hi_reg         <= '0;
      lo_reg         <= '0;
      md_b_reg       <= '0;
      md_store_reg   <= '0;
      md_dest_reg    <= '0;
      md_sel_reg     <= '0;
      out_valid_reg  <= 1'b0;
      out_result_reg <= '0;
      out_store_reg  <= '0;
      out_dest_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      hi_reg         <= hi_next;
      lo_reg         <= lo_next;
      md_b_reg       <= md_b_next;
      md_store_reg   <= md_store_next;
      md_dest_reg    <= md_dest_next;
      md_sel_reg     <= md_sel_next;
      out_valid_reg  <= out_valid_next;
      out_result_reg <= out_result_next;
      out_store_reg  <= out_store_next;
      out_dest_reg   <= out_dest_next;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_result = out_result_reg;
  assign out_store  = out_store_reg;
  assign out_dest   = out_dest_reg;

endmodule
